// File: rtl/motion_corrector_stream_if.sv
// rtl/motion_corrector_stream_if.sv - point-in / corrected-point-out stream bundle for the motion corrector
interface motion_corrector_stream_if #(
    parameter int WP   = 32,
    parameter int CNTW = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [WP-1:0]   px, py, pz;
    logic signed [WP-1:0]   dt;
    logic        [1:0]      mode;
    logic signed [WP-1:0]   d_x, d_y, d_z;
    logic signed [WP-1:0]   yaw;
    logic        [31:0]     inv_t;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [WP-1:0]   cx, cy, cz;
    logic                   out_clamped;
    logic                   out_sat;
    logic        [CNTW-1:0] clamp_count;
    logic        [CNTW-1:0] sat_count;
    logic        [31:0]     pt_count;

    modport slave (
        input  in_valid, px, py, pz, dt, mode, d_x, d_y, d_z, yaw, inv_t, out_ready,
        output in_ready, out_valid, cx, cy, cz, out_clamped, out_sat,
        output clamp_count, sat_count, pt_count
    );

    modport master (
        output in_valid, px, py, pz, dt, mode, d_x, d_y, d_z, yaw, inv_t, out_ready,
        input  in_ready, out_valid, cx, cy, cz, out_clamped, out_sat,
        input  clamp_count, sat_count, pt_count
    );
endinterface

// File: rtl/motion_corrector_stream.sv
// rtl/motion_corrector_stream.sv - 3-stage streaming LiDAR point deskew (translate + small-angle yaw)
module motion_corrector_stream #(
    parameter int WP   = 32,
    parameter int FRAC = 16,
    parameter int INVF = 24,
    parameter int CNTW = 16
) (
    input logic                     clk,
    input logic                     rst,
    motion_corrector_stream_if.slave s
);
    localparam int PW = 2 * WP;
    localparam int SW = 2 * WP + 2;
    localparam logic        [WP-1:0] ONE   = WP'(1) << FRAC;
    localparam logic signed [PW:0]   ONE_X = (PW + 1)'(1) << FRAC;

    function automatic logic signed [PW-1:0] mul_frac(input logic signed [WP-1:0] a,
                                                      input logic signed [WP-1:0] b);
        logic signed [PW-1:0] p;
        p = $signed({{WP{a[WP-1]}}, a}) * $signed({{WP{b[WP-1]}}, b});
        return p >>> FRAC;
    endfunction

    function automatic logic signed [SW-1:0] ext_w(input logic signed [WP-1:0] a);
        return $signed({{(SW - WP){a[WP-1]}}, a});
    endfunction

    function automatic logic signed [SW-1:0] ext_p(input logic signed [PW-1:0] a);
        return $signed({{(SW - PW){a[PW-1]}}, a});
    endfunction

    // Returns {saturated, value}: in range iff all bits above the WP-bit sign agree with it.
    function automatic logic [WP:0] sat(input logic signed [SW-1:0] v);
        if ((&v[SW-1:WP-1]) || !(|v[SW-1:WP-1]))
            return {1'b0, v[WP-1:0]};
        else if (v[SW-1])
            return {1'b1, 1'b1, {(WP - 1){1'b0}}};
        else
            return {1'b1, 1'b0, {(WP - 1){1'b1}}};
    endfunction

    // Whole pipeline advances together; bubbles are carried, not squeezed out.
    logic adv;
    assign adv        = !(s.out_valid && !s.out_ready);
    assign s.in_ready = adv;

    logic signed [PW:0]   prod, tau_full;
    logic        [WP-1:0] tau_c;
    logic                 clamp_c;

    always_comb begin
        prod     = $signed({{(WP + 1){s.dt[WP-1]}}, s.dt}) * $signed({{(PW + 1 - 32){1'b0}}, s.inv_t});
        tau_full = prod >>> INVF;
        tau_c    = tau_full[WP-1:0];
        clamp_c  = 1'b0;
        if (tau_full[PW]) begin
            tau_c   = '0;
            clamp_c = 1'b1;
        end else if (tau_full > ONE_X) begin
            tau_c   = ONE;
            clamp_c = 1'b1;
        end
    end

    logic                 s1_v, s1_clamp;
    logic        [1:0]    s1_mode;
    logic        [WP-1:0] s1_tau;
    logic signed [WP-1:0] s1_px, s1_py, s1_pz, s1_dx, s1_dy, s1_dz, s1_yaw;

    logic                 s2_v, s2_clamp;
    logic signed [WP-1:0] s2_px, s2_py, s2_pz, s2_ox, s2_oy, s2_oz, s2_theta;

    logic signed [SW-1:0] sx, sy, sz;
    logic        [WP:0]   rx, ry, rz;

    always_comb begin
        sx = ext_w(s2_px) - ext_w(s2_ox) - ext_p(mul_frac(s2_theta, s2_py));
        sy = ext_w(s2_py) - ext_w(s2_oy) + ext_p(mul_frac(s2_theta, s2_px));
        sz = ext_w(s2_pz) - ext_w(s2_oz);
        rx = sat(sx);
        ry = sat(sy);
        rz = sat(sz);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v          <= 1'b0;
            s2_v          <= 1'b0;
            s.out_valid   <= 1'b0;
            s.out_clamped <= 1'b0;
            s.out_sat     <= 1'b0;
            s.cx          <= '0;
            s.cy          <= '0;
            s.cz          <= '0;
            s.clamp_count <= '0;
            s.sat_count   <= '0;
            s.pt_count    <= '0;
        end else begin
            if (adv) begin
                s1_v     <= s.in_valid;
                s1_clamp <= clamp_c;
                s1_tau   <= tau_c;
                s1_mode  <= s.mode;
                s1_px    <= s.px;
                s1_py    <= s.py;
                s1_pz    <= s.pz;
                s1_dx    <= s.d_x;
                s1_dy    <= s.d_y;
                s1_dz    <= s.d_z;
                s1_yaw   <= s.yaw;

                // Mode 0 forces zero offsets so bypass is bit-exact; yaw only in modes 2/3.
                s2_v     <= s1_v;
                s2_clamp <= s1_clamp;
                s2_px    <= s1_px;
                s2_py    <= s1_py;
                s2_pz    <= s1_pz;
                s2_ox    <= (s1_mode == 2'd0) ? '0 : WP'(mul_frac(s1_dx, s1_tau));
                s2_oy    <= (s1_mode == 2'd0) ? '0 : WP'(mul_frac(s1_dy, s1_tau));
                s2_oz    <= (s1_mode == 2'd0) ? '0 : WP'(mul_frac(s1_dz, s1_tau));
                s2_theta <= s1_mode[1] ? WP'(mul_frac(s1_yaw, s1_tau)) : '0;

                s.out_valid   <= s2_v;
                s.out_clamped <= s2_clamp;
                s.out_sat     <= rx[WP] | ry[WP] | rz[WP];
                s.cx          <= rx[WP-1:0];
                s.cy          <= ry[WP-1:0];
                s.cz          <= rz[WP-1:0];
            end

            if (s.out_valid && s.out_ready) begin
                s.pt_count <= s.pt_count + 32'd1;
                if (s.out_clamped && (s.clamp_count != '1))
                    s.clamp_count <= s.clamp_count + CNTW'(1);
                if (s.out_sat && (s.sat_count != '1))
                    s.sat_count <= s.sat_count + CNTW'(1);
            end
        end
    end
endmodule

// File: tb/tb_motion_corrector_stream.sv
// tb/tb_motion_corrector_stream.sv - scoreboard bench for motion_corrector_stream
module tb_motion_corrector_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    motion_corrector_stream_if #(.WP(32), .CNTW(16)) mif();

    motion_corrector_stream #(.WP(32), .FRAC(16), .INVF(24), .CNTW(16)) dut (
        .clk(clk),
        .rst(rst),
        .s  (mif)
    );

    typedef struct {
        logic [31:0] cx, cy, cz;
        logic        clamped, sat;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   bp_en  = 1'b0;
    int   bp_idx = 0;
    bit   pat [8] = '{1, 0, 0, 0, 0, 1, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always begin
        mif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_en) begin
                mif.out_ready = pat[bp_idx % 8];
                bp_idx++;
            end else begin
                mif.out_ready = 1'b1;
            end
        end
    end

    exp_t        e;
    bit          pstall = 1'b0;
    logic [31:0] pcx;

    always @(negedge clk) begin
        if (rst) begin
            pstall = 1'b0;
        end else begin
            if (bp_en) check("in_ready", {31'b0, mif.in_ready}, {31'b0, !(mif.out_valid && !mif.out_ready)});
            if (pstall) begin
                check("hold_valid", {31'b0, mif.out_valid}, 32'd1);
                check("hold_cx", mif.cx, pcx);
            end
            if (mif.out_valid && mif.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", {31'b0, mif.out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("cx", mif.cx, e.cx);
                    check("cy", mif.cy, e.cy);
                    check("cz", mif.cz, e.cz);
                    check("clamped", {31'b0, mif.out_clamped}, {31'b0, e.clamped});
                    check("sat", {31'b0, mif.out_sat}, {31'b0, e.sat});
                    if (e.chk_lat) check("latency", cyc - e.acc, 32'd3);
                end
            end
            pstall = mif.out_valid && !mif.out_ready;
            pcx    = mif.cx;
        end
    end

    task automatic send(input logic [31:0] px, py, pz, dt, input logic [1:0] mode,
                        input logic [31:0] dx, dy, dz, yaw, inv,
                        input logic [31:0] ecx, ecy, ecz, input logic ecl, esat, input bit lat);
        bit   hs = 1'b0;
        int   n  = 0;
        exp_t x;
        mif.in_valid = 1'b1;
        mif.px = px;   mif.py = py;   mif.pz = pz;   mif.dt = dt;   mif.mode = mode;
        mif.d_x = dx;  mif.d_y = dy;  mif.d_z = dz;  mif.yaw = yaw; mif.inv_t = inv;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = mif.in_ready;
            if (hs) begin
                x.cx = ecx; x.cy = ecy; x.cz = ecz; x.clamped = ecl; x.sat = esat;
                x.acc = cyc; x.chk_lat = lat;
                sb.push_back(x);
            end
            @(posedge clk);
            #1;
            n++;
        end
        mif.in_valid = 1'b0;
        if (!hs) check("send_timeout", {31'b0, mif.in_ready}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] INV5 = 32'd83886080;
    localparam logic [31:0] INV1 = 32'd16777216;

    initial begin
        mif.in_valid = 1'b0;
        mif.px = '0; mif.py = '0; mif.pz = '0; mif.dt = '0; mif.mode = '0;
        mif.d_x = '0; mif.d_y = '0; mif.d_z = '0; mif.yaw = '0; mif.inv_t = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", {31'b0, mif.out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, mif.in_ready}, 32'd1);
        check("rst_cx", mif.cx, 32'd0);
        check("rst_clamped", {31'b0, mif.out_clamped}, 32'd0);
        check("rst_sat", {31'b0, mif.out_sat}, 32'd0);
        check("rst_pt_count", mif.pt_count, 32'd0);
        check("rst_clamp_count", {16'b0, mif.clamp_count}, 32'd0);
        check("rst_sat_count", {16'b0, mif.sat_count}, 32'd0);

        // Backpressure: 8 distinct translated points under a toggling out_ready.
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] bpx, bdt;
            bpx = ((i + 1) << 16) + i;
            bdt = i * 4096;
            send(bpx, i, -i, bdt, 2'd1, 32'd65536, 0, 0, 0, INV1,
                 bpx - bdt, i, -i, 1'b0, 1'b0, 1'b0);
        end
        drain();
        bp_en = 1'b0;
        check("bp_pt_count", mif.pt_count, 32'd8);

        // Translate and clamp at both ends of the scan.
        send(32'd655360, 32'd131072, 32'hFFFF0000, 32'd6553, 2'd1, 32'd196608, 0, 0, 0, INV5,
             32'd557065, 32'd131072, 32'hFFFF0000, 1'b0, 1'b0, 1'b1);
        send(32'd655360, 32'd131072, 32'hFFFF0000, 32'd19660, 2'd1, 32'd196608, 0, 0, 0, INV5,
             32'd458752, 32'd131072, 32'hFFFF0000, 1'b1, 1'b0, 1'b1);
        drain();
        check("clamp_count_1", {16'b0, mif.clamp_count}, 32'd1);
        send(32'd655360, 32'd131072, 32'hFFFF0000, 32'hFFFFFD71, 2'd1, 32'd196608, 0, 0, 0, INV5,
             32'd655360, 32'd131072, 32'hFFFF0000, 1'b1, 1'b0, 1'b1);
        drain();
        check("clamp_count_2", {16'b0, mif.clamp_count}, 32'd2);

        // Yaw in modes 2, 1 and 3.
        send(32'd655360, 0, 0, 32'd16384, 2'd2, 0, 0, 0, 32'd6553, INV5,
             32'd655360, 32'd65530, 0, 1'b1, 1'b0, 1'b1);
        send(32'd655360, 0, 0, 32'd16384, 2'd1, 0, 0, 0, 32'd6553, INV5,
             32'd655360, 0, 0, 1'b1, 1'b0, 1'b1);
        send(32'd655360, 0, 0, 32'd16384, 2'd3, 0, 0, 0, 32'd6553, INV5,
             32'd655360, 32'd65530, 0, 1'b1, 1'b0, 1'b1);

        // Saturation at tau exactly 1.0, then bypass of the same point.
        send(32'h7FFF0000, 0, 0, 32'd65536, 2'd1, 32'hFFFE0000, 0, 0, 0, INV1,
             32'h7FFFFFFF, 0, 0, 1'b0, 1'b1, 1'b1);
        send(32'h7FFF0000, 0, 0, 32'd65536, 2'd0, 32'hFFFE0000, 0, 0, 0, INV1,
             32'h7FFF0000, 0, 0, 1'b0, 1'b0, 1'b1);
        send(32'd655360, 32'd1, 32'd2, 32'hFFFFFD71, 2'd0, 32'd196608, 0, 0, 0, INV5,
             32'd655360, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1);
        drain();
        check("clamp_count_6", {16'b0, mif.clamp_count}, 32'd6);
        check("sat_count_1", {16'b0, mif.sat_count}, 32'd1);
        check("pt_count_17", mif.pt_count, 32'd17);

        // Reset with two points in flight.
        send(32'd100, 32'd200, 32'd300, 0, 2'd0, 0, 0, 0, 0, INV1, 32'd100, 32'd200, 32'd300, 1'b0, 1'b0, 1'b1);
        send(32'd101, 32'd201, 32'd301, 0, 2'd0, 0, 0, 0, 0, INV1, 32'd101, 32'd201, 32'd301, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("mid_rst_in_ready", {31'b0, mif.in_ready}, 32'd1);
        check("mid_rst_pt_count", mif.pt_count, 32'd0);
        check("mid_rst_clamp_count", {16'b0, mif.clamp_count}, 32'd0);
        check("mid_rst_sat_count", {16'b0, mif.sat_count}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("post_rst_valid", {31'b0, mif.out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(32'd777, 32'd888, 32'd999, 0, 2'd0, 0, 0, 0, 0, INV1, 32'd777, 32'd888, 32'd999, 1'b0, 1'b0, 1'b1);
        drain();
        check("post_rst_pt_count", mif.pt_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/motion_corrector_stream.md
# motion_corrector_stream

Streaming, pipelined successor to the combinational motion corrector. It deskews one LiDAR point per cycle using the point's intra-scan timestamp. It applies linear displacement and optional small-angle yaw compensation over the scan, referenced to scan start. It sits between the point-unpack stage and the point-cloud writer, with valid/ready handshakes on both sides, saturating fixed-point arithmetic, and diagnostic counters.

## Interface
- WP, 32, signed point/velocity/timestamp word width
- FRAC, 16, fractional bits of all QWP-FRAC.FRAC signals (px..pz, dt, d_*, yaw, cx..cz)
- INVF, 24, fractional bits of unsigned inv_t (UQ(32-INVF).INVF)
- CNTW, 16, width of diagnostic counters
---
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input point valid
- in_ready  out  1  block can accept a point this cycle
- px, py, pz  in  WP  signed point coordinates
- dt  in  WP  signed time since scan start, seconds
- mode  in  2  0 bypass, 1 translate, 2 translate+yaw, 3 treated as 2
- d_x, d_y, d_z  in  WP  signed displacement over one full scan, metres
- yaw  in  WP  signed yaw change over one full scan, radians
- inv_t  in  32  1/scan period, UQ(32-INVF).INVF
- out_valid  out  1  corrected point valid
- out_ready  in  1  downstream accepts
- cx, cy, cz  out  WP  corrected coordinates
- out_clamped  out  1  tau of this point was clamped
- out_sat  out  1  any output component saturated
- clamp_count, sat_count  out  CNTW  saturating event counters
- pt_count  out  32  points delivered (wraps)

## Operation
- Accept: in_valid && in_ready. mode, d_*, yaw, inv_t sampled with each accepted point; changes affect only later points.
- Stage 1: prod = dt * inv_t (signed x unsigned, 2WP+1 bits); tau = prod >>> INVF, giving Q.FRAC. If tau < 0, force tau = 0 and set the clamp flag. If tau > 1<<FRAC, force tau = 1<<FRAC and set the clamp flag. tau = exactly 1.0 is not clamped.
- Stage 2: o_k = (d_k * tau) >>> FRAC for k in {x,y,z}; theta = (yaw * tau) >>> FRAC. In mode 1, theta is 0. In mode 0, all o_k and theta are 0.
- Stage 3, computed at full width then saturated:
  - cx = px - o_x - ((theta*py) >>> FRAC)
  - cy = py - o_y + ((theta*px) >>> FRAC)
  - cz = pz - o_z
- Saturation limits: saturate to [-2^(WP-1), 2^(WP-1)-1]. Any saturation sets out_sat.
- All right-shifts are arithmetic (floor).
- Mode 0: cx..cz = px..pz exactly. out_clamped is still reported.
- Counters:
  - clamp_count and sat_count increment on output handshake (out_valid && out_ready) when the respective flag is set, and hold at all-ones.
  - pt_count increments on every output handshake and wraps.

## Timing
- 3-stage pipeline; latency from input handshake to out_valid is 3 cycles when not stalled. Throughput is 1 point/cycle.
- Stall: the whole pipeline holds when out_valid && !out_ready. in_ready = !(out_valid && !out_ready), which is combinational from out_ready. Bubbles are not compressed.
- Outputs and flags are stable while out_valid && !out_ready.
- Order is preserved; no drop or duplication under any valid/ready pattern.
- Reset values:
  - out_valid, out_clamped, out_sat: 0
  - cx, cy, cz: 0
  - all counters: 0
  - in_ready: 1 in the first cycle after reset.
- Reset mid-stream: in-flight points are discarded and no out_valid occurs in the cycle after rst is deasserted. rst dominates a simultaneous handshake.

## Test plan
- Translate: mode=1, inv_t=83886080 (T=0.2 s), d_x=196608 (3.0), px=655360, dt=6553 -> tau=32765; cx=557065, cy=py, cz=pz; out_valid 3 cycles after accept.
- Clamp: same setup, dt=19660 (0.3 s) -> tau=65536; cx=458752 (7.0), out_clamped=1, clamp_count=1. dt=-655 -> cx=px, clamp_count=2.
- Yaw: mode=2, d=0, yaw=6553, dt=16384 (clamped), px=655360, py=0 -> cx=655360, cy=65530. Same point with mode=1 -> cy=0.
- Saturation: mode=1, px=0x7FFF0000, d_x=-131072, tau=1.0 -> cx=0x7FFFFFFF, out_sat=1, sat_count=1. Bypass (mode=0) of the same point -> cx=0x7FFF0000, out_sat=0.
- Backpressure: stream 8 distinct points, out_ready toggled pattern 1,0,0,0,0,1,0,1... -> in_ready low exactly while stalled, outputs in order, no loss, pt_count=8.
- Reset: assert rst for 1 cycle with 2 points in flight -> no out_valid afterwards, all counters 0. The next point emerges with latency 3.
